// File: rtl/reg_file_arbiter_amisha_if.sv
// Bundle between the two requesters / register file (master side) and the
// arbiter-sequencer (slave side).
interface reg_file_arbiter_amisha_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 2
);
    logic                  req0_amisha;
    logic                  we0_amisha;
    logic [ADDR_WIDTH-1:0] addr0_amisha;
    logic [DATA_WIDTH-1:0] wdata0_amisha;

    logic                  req1_amisha;
    logic                  we1_amisha;
    logic [ADDR_WIDTH-1:0] addr1_amisha;
    logic [DATA_WIDTH-1:0] wdata1_amisha;

    logic                  done0_amisha;
    logic                  done1_amisha;
    logic [DATA_WIDTH-1:0] rdata_amisha;
    logic                  busy_amisha;

    logic                  rf_wr_en_amisha;
    logic [ADDR_WIDTH-1:0] rf_w_addr_amisha;
    logic [DATA_WIDTH-1:0] rf_w_data_amisha;
    logic [ADDR_WIDTH-1:0] rf_r_addr_amisha;
    logic [DATA_WIDTH-1:0] rf_r_data_amisha;

    modport master (
        output req0_amisha, we0_amisha, addr0_amisha, wdata0_amisha,
        output req1_amisha, we1_amisha, addr1_amisha, wdata1_amisha,
        output rf_r_data_amisha,
        input  done0_amisha, done1_amisha, rdata_amisha, busy_amisha,
        input  rf_wr_en_amisha, rf_w_addr_amisha, rf_w_data_amisha, rf_r_addr_amisha
    );

    modport slave (
        input  req0_amisha, we0_amisha, addr0_amisha, wdata0_amisha,
        input  req1_amisha, we1_amisha, addr1_amisha, wdata1_amisha,
        input  rf_r_data_amisha,
        output done0_amisha, done1_amisha, rdata_amisha, busy_amisha,
        output rf_wr_en_amisha, rf_w_addr_amisha, rf_w_data_amisha, rf_r_addr_amisha
    );
endinterface

// File: rtl/reg_file_arbiter_amisha.sv
// Two-requester round-robin arbiter that serializes single read/write
// transactions onto a 1W/1R register file, three cycles per transaction.
module reg_file_arbiter_amisha #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 2
) (
    input logic                      clk_amisha,
    input logic                      reset_amisha,
    reg_file_arbiter_amisha_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nxt;

    logic                  ptr;
    logic                  ptr_nxt;

    logic                  lat_we;
    logic                  lat_we_nxt;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [ADDR_WIDTH-1:0] lat_addr_nxt;
    logic [DATA_WIDTH-1:0] lat_wdata;
    logic [DATA_WIDTH-1:0] lat_wdata_nxt;
    logic                  lat_id;
    logic                  lat_id_nxt;

    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] rdata_nxt;

    logic                  any_req;
    logic                  grant;

    always_ff @(posedge clk_amisha or posedge reset_amisha) begin
        if (reset_amisha) begin
            state     <= IDLE;
            ptr       <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_id    <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            lat_we    <= lat_we_nxt;
            lat_addr  <= lat_addr_nxt;
            lat_wdata <= lat_wdata_nxt;
            lat_id    <= lat_id_nxt;
            rdata_q   <= rdata_nxt;
        end
    end

    // Pointer only breaks ties; a lone requester always wins.
    always_comb begin
        any_req = bus.req0_amisha | bus.req1_amisha;
        if (bus.req0_amisha && bus.req1_amisha) begin
            grant = ptr;
        end else begin
            grant = bus.req1_amisha;
        end
    end

    always_comb begin
        state_nxt     = state;
        ptr_nxt       = ptr;
        lat_we_nxt    = lat_we;
        lat_addr_nxt  = lat_addr;
        lat_wdata_nxt = lat_wdata;
        lat_id_nxt    = lat_id;
        rdata_nxt     = rdata_q;

        unique case (state)
            IDLE: begin
                if (any_req) begin
                    lat_id_nxt = grant;
                    if (grant) begin
                        lat_we_nxt    = bus.we1_amisha;
                        lat_addr_nxt  = bus.addr1_amisha;
                        lat_wdata_nxt = bus.wdata1_amisha;
                    end else begin
                        lat_we_nxt    = bus.we0_amisha;
                        lat_addr_nxt  = bus.addr0_amisha;
                        lat_wdata_nxt = bus.wdata0_amisha;
                    end
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                // The register file commits the write on this same edge.
                if (!lat_we) begin
                    rdata_nxt = bus.rf_r_data_amisha;
                end
                state_nxt = RESP;
            end
            RESP: begin
                ptr_nxt   = ~lat_id;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // All outputs decode from registered state only.
    assign bus.busy_amisha      = (state != IDLE);
    assign bus.rf_wr_en_amisha  = (state == ACCESS) && lat_we;
    assign bus.rf_w_addr_amisha = lat_addr;
    assign bus.rf_r_addr_amisha = lat_addr;
    assign bus.rf_w_data_amisha = lat_wdata;
    assign bus.done0_amisha     = (state == RESP) && !lat_id;
    assign bus.done1_amisha     = (state == RESP) && lat_id;
    assign bus.rdata_amisha     = rdata_q;

    a_done_onehot: assert property (@(posedge clk_amisha) disable iff (reset_amisha)
        !(bus.done0_amisha && bus.done1_amisha));

    a_done_in_resp: assert property (@(posedge clk_amisha) disable iff (reset_amisha)
        (bus.done0_amisha || bus.done1_amisha) |-> (state == RESP));

    a_wr_in_access: assert property (@(posedge clk_amisha) disable iff (reset_amisha)
        bus.rf_wr_en_amisha |-> (state == ACCESS));

    a_resp_to_idle: assert property (@(posedge clk_amisha) disable iff (reset_amisha)
        (state == RESP) |=> (state == IDLE));
endmodule

// File: tb/tb_reg_file_arbiter_amisha.sv
// Bench for reg_file_arbiter_amisha: directed vector table, hand-written
// reset/hold sequences and a randomized run against a transaction-level model.
module tb_reg_file_arbiter_amisha;
    logic clk;
    logic rst;

    reg_file_arbiter_amisha_if #(.DATA_WIDTH(8), .ADDR_WIDTH(2)) bus ();

    reg_file_arbiter_amisha #(.DATA_WIDTH(8), .ADDR_WIDTH(2)) dut (
        .clk_amisha   (clk),
        .reset_amisha (rst),
        .bus          (bus)
    );

    logic [7:0] rf_mem [4];
    always @(posedge clk) begin
        if (bus.rf_wr_en_amisha) rf_mem[bus.rf_w_addr_amisha] <= bus.rf_w_data_amisha;
    end
    assign bus.rf_r_data_amisha = rf_mem[bus.rf_r_addr_amisha];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vec_cnt = 0;
    int err_cnt = 0;

    typedef struct {
        bit         rst;
        bit         r0;
        bit         w0;
        logic [1:0] a0;
        logic [7:0] d0;
        bit         r1;
        bit         w1;
        logic [1:0] a1;
        logic [7:0] d1;
        bit         id;
        logic [7:0] rd;
    } vec_t;

    vec_t tbl [14];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.req0_amisha = 0; bus.we0_amisha = 0; bus.addr0_amisha = 0; bus.wdata0_amisha = 0;
        bus.req1_amisha = 0; bus.we1_amisha = 0; bus.addr1_amisha = 0; bus.wdata1_amisha = 0;
    endtask

    // Entered in IDLE with requests already driven; leaves in the following IDLE.
    task automatic run_txn(input bit id, input bit we, input logic [1:0] addr,
                           input logic [7:0] wdata, input logic [7:0] exp_rd, input string tag);
        step();
        chk({tag, ".acc_busy"},  bus.busy_amisha, 1);
        chk({tag, ".acc_wr_en"}, bus.rf_wr_en_amisha, we);
        chk({tag, ".acc_waddr"}, bus.rf_w_addr_amisha, addr);
        chk({tag, ".acc_raddr"}, bus.rf_r_addr_amisha, addr);
        chk({tag, ".acc_wdata"}, bus.rf_w_data_amisha, wdata);
        chk({tag, ".acc_done"},  {bus.done1_amisha, bus.done0_amisha}, 0);
        if (we) chk({tag, ".acc_rdata"}, bus.rdata_amisha, exp_rd);
        step();
        chk({tag, ".rsp_busy"},  bus.busy_amisha, 1);
        chk({tag, ".rsp_wr_en"}, bus.rf_wr_en_amisha, 0);
        chk({tag, ".rsp_done"},  {bus.done1_amisha, bus.done0_amisha}, id ? 2'b10 : 2'b01);
        chk({tag, ".rsp_rdata"}, bus.rdata_amisha, exp_rd);
        if (id) bus.req1_amisha = 0; else bus.req0_amisha = 0;
        step();
        chk({tag, ".idl_busy"},  bus.busy_amisha, 0);
        chk({tag, ".idl_wr_en"}, bus.rf_wr_en_amisha, 0);
        chk({tag, ".idl_done"},  {bus.done1_amisha, bus.done0_amisha}, 0);
        chk({tag, ".idl_rdata"}, bus.rdata_amisha, exp_rd);
    endtask

    task automatic pulse_reset();
        rst = 1;
        step();
        step();
        rst = 0;
    endtask

    bit         p_v  [2];
    bit         p_we [2];
    logic [1:0] p_a  [2];
    logic [7:0] p_d  [2];
    logic [7:0] m_mem [4];
    logic [7:0] m_last;
    bit         m_ptr;
    bit         win;
    logic [7:0] exp_rd;

    initial begin
        // req0..d0, req1..d1, winner id, rdata seen in RESP
        tbl[0]  = '{0, 0,0,2'd0,8'h00, 1,1,2'd1,8'd7,  1, 8'd0};
        tbl[1]  = '{0, 1,1,2'd2,8'd11, 0,0,2'd0,8'h00, 0, 8'd0};
        tbl[2]  = '{0, 0,0,2'd0,8'h00, 1,1,2'd3,8'd16, 1, 8'd0};
        tbl[3]  = '{0, 1,0,2'd2,8'h00, 0,0,2'd0,8'h00, 0, 8'd11};
        tbl[4]  = '{0, 0,0,2'd0,8'h00, 1,0,2'd1,8'h00, 1, 8'd7};
        tbl[5]  = '{0, 1,0,2'd3,8'h00, 0,0,2'd0,8'h00, 0, 8'd16};
        tbl[6]  = '{1, 1,0,2'd2,8'h00, 1,0,2'd3,8'h00, 0, 8'd11};
        tbl[7]  = '{0, 1,0,2'd2,8'h00, 1,0,2'd3,8'h00, 1, 8'd16};
        tbl[8]  = '{0, 1,0,2'd2,8'h00, 1,0,2'd3,8'h00, 0, 8'd11};
        tbl[9]  = '{0, 1,0,2'd2,8'h00, 1,0,2'd3,8'h00, 1, 8'd16};
        tbl[10] = '{0, 0,0,2'd0,8'h00, 1,1,2'd0,8'h5A, 1, 8'd16};
        tbl[11] = '{0, 0,0,2'd0,8'h00, 1,0,2'd0,8'h00, 1, 8'h5A};
        tbl[12] = '{0, 1,0,2'd3,8'h00, 1,1,2'd0,8'h66, 0, 8'd16};
        tbl[13] = '{0, 0,0,2'd0,8'h00, 1,1,2'd0,8'h66, 1, 8'd16};

        rst = 1;
        clear_inputs();
        step();
        step();
        chk("rst_busy",  bus.busy_amisha, 0);
        chk("rst_done",  {bus.done1_amisha, bus.done0_amisha}, 0);
        chk("rst_wr_en", bus.rf_wr_en_amisha, 0);
        chk("rst_rdata", bus.rdata_amisha, 0);
        chk("rst_waddr", bus.rf_w_addr_amisha, 0);
        chk("rst_wdata", bus.rf_w_data_amisha, 0);
        rst = 0;
        step();

        // Single write by requester 0
        bus.req0_amisha = 1; bus.we0_amisha = 1; bus.addr0_amisha = 0; bus.wdata0_amisha = 8'd2;
        run_txn(0, 1, 2'd0, 8'd2, 8'd0, "t1");

        for (int i = 0; i < 14; i++) begin
            if (tbl[i].rst) pulse_reset();
            bus.req0_amisha = tbl[i].r0; bus.we0_amisha = tbl[i].w0;
            bus.addr0_amisha = tbl[i].a0; bus.wdata0_amisha = tbl[i].d0;
            bus.req1_amisha = tbl[i].r1; bus.we1_amisha = tbl[i].w1;
            bus.addr1_amisha = tbl[i].a1; bus.wdata1_amisha = tbl[i].d1;
            if (tbl[i].id)
                run_txn(1, tbl[i].w1, tbl[i].a1, tbl[i].d1, tbl[i].rd, $sformatf("row%0d", i));
            else
                run_txn(0, tbl[i].w0, tbl[i].a0, tbl[i].d0, tbl[i].rd, $sformatf("row%0d", i));
        end
        clear_inputs();

        // Reset asserted mid-ACCESS aborts a write to addr 2
        bus.req0_amisha = 1; bus.we0_amisha = 1; bus.addr0_amisha = 2; bus.wdata0_amisha = 8'hAA;
        step();
        chk("abort.pre_wr_en", bus.rf_wr_en_amisha, 1);
        #2 rst = 1;
        #1;
        chk("abort.async_wr_en", bus.rf_wr_en_amisha, 0);
        chk("abort.async_busy",  bus.busy_amisha, 0);
        chk("abort.async_done",  {bus.done1_amisha, bus.done0_amisha}, 0);
        bus.req0_amisha = 0;
        step();
        rst = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("abort.quiet_done", {bus.done1_amisha, bus.done0_amisha}, 0);
            chk("abort.quiet_busy", bus.busy_amisha, 0);
        end
        bus.req0_amisha = 1; bus.we0_amisha = 0; bus.addr0_amisha = 2;
        run_txn(0, 0, 2'd2, 8'hAA, 8'd11, "abort_rd");

        // rdata must survive a later write transaction
        bus.req0_amisha = 1; bus.we0_amisha = 0; bus.addr0_amisha = 1; bus.wdata0_amisha = 0;
        run_txn(0, 0, 2'd1, 8'd0, 8'd7, "hold_rd");
        clear_inputs();
        bus.req1_amisha = 1; bus.we1_amisha = 1; bus.addr1_amisha = 0; bus.wdata1_amisha = 8'h44;
        run_txn(1, 1, 2'd0, 8'h44, 8'd7, "hold_wr");
        clear_inputs();

        // Randomized traffic against a transaction-level model
        m_mem[0] = 8'h44; m_mem[1] = 8'd7; m_mem[2] = 8'd11; m_mem[3] = 8'd16;
        m_last = 8'd7;
        m_ptr  = 0;
        p_v[0] = 0; p_v[1] = 0;
        for (int it = 0; it < 200; it++) begin
            for (int r = 0; r < 2; r++) begin
                if (!p_v[r] && $urandom_range(0, 2) != 0) begin
                    p_v[r]  = 1;
                    p_we[r] = 1'($urandom_range(0, 1));
                    p_a[r]  = 2'($urandom_range(0, 3));
                    p_d[r]  = 8'($urandom_range(0, 255));
                end
            end
            bus.req0_amisha = p_v[0]; bus.we0_amisha = p_we[0];
            bus.addr0_amisha = p_a[0]; bus.wdata0_amisha = p_d[0];
            bus.req1_amisha = p_v[1]; bus.we1_amisha = p_we[1];
            bus.addr1_amisha = p_a[1]; bus.wdata1_amisha = p_d[1];
            if (!p_v[0] && !p_v[1]) begin
                step();
                chk("rand.idle_busy", bus.busy_amisha, 0);
                chk("rand.idle_done", {bus.done1_amisha, bus.done0_amisha}, 0);
            end else begin
                win = (p_v[0] && p_v[1]) ? m_ptr : p_v[1];
                if (p_we[win]) begin
                    exp_rd = m_last;
                    m_mem[p_a[win]] = p_d[win];
                end else begin
                    exp_rd = m_mem[p_a[win]];
                    m_last = exp_rd;
                end
                m_ptr = ~win;
                run_txn(win, p_we[win], p_a[win], p_d[win], exp_rd, $sformatf("rand%0d", it));
                p_v[win] = 0;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
